// File: rtl/towns_sram_pkg.sv
// Shared types and constants for the TOWNS CMOS/SRAM upload responder.
// Optional feature macro used by the top: SRAM_AUTOSAVE_EN.
package towns_sram_pkg;

    // Upload responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_FETCH  = 2'd3
    } state_t;

    // Default ioctl file index this block answers to
    localparam logic [7:0] UL_INDEX_DEF = 8'd1;

    // Byte returned for reads outside the image and after reset
    localparam logic [7:0] FILL_BYTE = 8'hFF;

    // Observation bundle: FSM state, dirty flag, sticky host-overlap flag
    typedef struct packed {
        state_t state;
        logic   dirty;
        logic   rd_overlap;
    } dbg_t;

endpackage

// File: rtl/towns_sram_idle_timer.sv
// Quiet-period timer for CMOS autosave: counts cycles while enabled,
// restarts on every clear, and flags expiry at LIMIT-1.
// Only instantiated when SRAM_AUTOSAVE_EN is defined.
module towns_sram_idle_timer #(
    parameter int              W     = 24,
    parameter logic [W-1:0]    LIMIT = 24'd10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [W-1:0] cnt;

    assign expire = enable && (cnt == LIMIT - W'(1));

    // Count while enabled; any clear or loss of enable restarts the period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || !enable) begin
            cnt <= '0;
        end else if (!expire) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/towns_sram_uploader.sv
// HPS ioctl upload responder: streams the CMOS/SRAM image back to the host.
// A save trigger raises ioctl_upload_req; each host read is then served
// through a req/ack fetch on the CMOS RAM's second read port.
// Optional feature: define SRAM_AUTOSAVE_EN to save automatically once the
// CMOS has been quiet for IDLE_CYC cycles after a write.
import towns_sram_pkg::*;

module towns_sram_uploader #(
    parameter int          AW       = 13,
    parameter logic [7:0]  UL_INDEX = UL_INDEX_DEF,
    parameter logic [23:0] REQ_TMO  = 24'd5000000,
    parameter logic [23:0] IDLE_CYC = 24'd10000000
) (
    input  logic          sysclk,
    input  logic          rstn,
    input  logic          save_trig,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic          ioctl_upload_req,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic          mem_ack,
    input  logic [7:0]    mem_rdat,
    input  logic          cmos_wr,
    output logic          busy,
    output dbg_t          dbg
);

    state_t      state;
    logic        save_q;
    logic [23:0] tmo_cnt;
    logic        abort_pend;
    logic        rd_overlap;
    logic        dirty;
    logic        autosave;
    logic        sel;
    logic        in_range;
    logic        start;

    assign sel      = ioctl_upload && (ioctl_index == UL_INDEX);
    assign in_range = (ioctl_addr[24:AW] == '0);

`ifdef SRAM_AUTOSAVE_EN
    towns_sram_idle_timer #(
        .W     (24),
        .LIMIT (IDLE_CYC)
    ) u_idle_timer (
        .clk    (sysclk),
        .rst_n  (rstn),
        .clear  (cmos_wr),
        .enable ((state == ST_IDLE) && dirty),
        .expire (autosave)
    );
`else
    logic unused_idle_cfg;
    assign unused_idle_cfg = ^IDLE_CYC;
    assign autosave        = 1'b0;
`endif

    assign start = (save_trig && !save_q) || autosave;
    assign busy  = (state != ST_IDLE);

    assign dbg.state      = state;
    assign dbg.dirty      = dirty;
    assign dbg.rd_overlap = rd_overlap;

    // Delay save_trig one cycle for rising-edge detection
    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            save_q <= 1'b0;
        end else begin
            save_q <= save_trig;
        end
    end

    // Dirty tracking: a CMOS write always wins over a completed-upload clear
    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            dirty <= 1'b0;
        end else if (cmos_wr) begin
            dirty <= 1'b1;
        end else if ((state == ST_ACTIVE) && !ioctl_upload) begin
            dirty <= 1'b0;
        end
    end

    // Upload request / host read service FSM with registered outputs
    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            state            <= ST_IDLE;
            ioctl_upload_req <= 1'b0;
            tmo_cnt          <= '0;
            mem_addr         <= '0;
            mem_rd           <= 1'b0;
            ioctl_wait       <= 1'b0;
            ioctl_din        <= FILL_BYTE;
            abort_pend       <= 1'b0;
            rd_overlap       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state            <= ST_REQ;
                        ioctl_upload_req <= 1'b1;
                        tmo_cnt          <= '0;
                    end
                end
                ST_REQ: begin
                    if (sel) begin
                        state            <= ST_ACTIVE;
                        ioctl_upload_req <= 1'b0;
                    end else if (tmo_cnt == REQ_TMO - 24'd1) begin
                        state            <= ST_IDLE;
                        ioctl_upload_req <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 24'd1;
                    end
                end
                ST_ACTIVE: begin
                    if (!ioctl_upload) begin
                        state <= ST_IDLE;
                    end else if (ioctl_rd && sel) begin
                        if (in_range) begin
                            state      <= ST_FETCH;
                            mem_addr   <= ioctl_addr[AW-1:0];
                            mem_rd     <= 1'b1;
                            ioctl_wait <= 1'b1;
                            abort_pend <= 1'b0;
                        end else begin
                            ioctl_din <= FILL_BYTE;
                        end
                    end
                end
                ST_FETCH: begin
                    // A host read while stalled is a protocol violation; note it only
                    if (ioctl_rd) begin
                        rd_overlap <= 1'b1;
                    end
                    if (!ioctl_upload) begin
                        abort_pend <= 1'b1;
                    end
                    // The RAM handshake is always completed, even if the host left
                    if (mem_ack) begin
                        mem_rd     <= 1'b0;
                        ioctl_wait <= 1'b0;
                        abort_pend <= 1'b0;
                        if (abort_pend || !ioctl_upload) begin
                            state <= ST_IDLE;
                        end else begin
                            ioctl_din <= mem_rdat;
                            state     <= ST_ACTIVE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_towns_sram_uploader.sv
// Directed + randomized bench for towns_sram_uploader (REQ_TMO=100, IDLE_CYC=50).
module tb_towns_sram_uploader;
    import towns_sram_pkg::*;

    localparam int AW = 13;
    localparam int IMG = 1 << AW;

    logic          sysclk;
    logic          rstn;
    logic          save_trig;
    logic          ioctl_upload;
    logic [7:0]    ioctl_index;
    logic          ioctl_rd;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_din;
    logic          ioctl_wait;
    logic          ioctl_upload_req;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_ack;
    logic [7:0]    mem_rdat;
    logic          cmos_wr;
    logic          busy;
    dbg_t          dbg;

    int n_eval = 0;
    int n_fail = 0;

    // Reference model: image contents and expected returned bytes
    logic [7:0] mem_model [0:IMG-1];
    logic [7:0] exp_q [$];
    logic [7:0] last_din;

    towns_sram_uploader #(
        .AW       (AW),
        .UL_INDEX (8'd1),
        .REQ_TMO  (24'd100),
        .IDLE_CYC (24'd50)
    ) dut (
        .sysclk           (sysclk),
        .rstn             (rstn),
        .save_trig        (save_trig),
        .ioctl_upload     (ioctl_upload),
        .ioctl_index      (ioctl_index),
        .ioctl_rd         (ioctl_rd),
        .ioctl_addr       (ioctl_addr),
        .ioctl_din        (ioctl_din),
        .ioctl_wait       (ioctl_wait),
        .ioctl_upload_req (ioctl_upload_req),
        .mem_addr         (mem_addr),
        .mem_rd           (mem_rd),
        .mem_ack          (mem_ack),
        .mem_rdat         (mem_rdat),
        .cmos_wr          (cmos_wr),
        .busy             (busy),
        .dbg              (dbg)
    );

    // Clock and watchdog
    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge sysclk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Host read of one byte; RAM answers after lat cycles with model data
    task automatic do_read(input logic [24:0] addr, input int lat);
        logic [7:0] exp;
        bit         hit;
        hit = (addr < 25'(IMG));
        if (hit) exp_q.push_back(mem_model[addr[AW-1:0]]);
        else     exp_q.push_back(FILL_BYTE);
        ioctl_rd   = 1'b1;
        ioctl_addr = addr;
        tick();
        ioctl_rd = 1'b0;
        if (hit) begin
            check("rd_mem_addr", 32'(mem_addr), 32'(addr[AW-1:0]));
            for (int k = 1; k <= lat; k++) begin
                if (k > 1) tick();
                check("rd_wait_hold", 32'(ioctl_wait), 32'd1);
                check("rd_mem_rd_hold", 32'(mem_rd), 32'd1);
            end
            mem_ack  = 1'b1;
            mem_rdat = mem_model[addr[AW-1:0]];
            tick();
            mem_ack  = 1'b0;
            mem_rdat = 8'($urandom);
        end
        check("rd_wait_done", 32'(ioctl_wait), 32'd0);
        check("rd_mem_rd_done", 32'(mem_rd), 32'd0);
        exp = exp_q.pop_front();
        check("rd_din", 32'(ioctl_din), 32'(exp));
        check("rd_state", 32'(dbg.state), 32'(ST_ACTIVE));
        last_din = exp;
    endtask

    // Save trigger, other-index upload ignored, then matching upload
    task automatic start_session();
        save_trig = 1'b0;
        tick();
        save_trig = 1'b1;
        tick();
        check("sess_req", 32'(ioctl_upload_req), 32'd1);
        ioctl_index  = 8'd2;
        ioctl_upload = 1'b1;
        tick();
        tick();
        check("sess_other_idx", 32'(dbg.state), 32'(ST_REQ));
        ioctl_index = 8'd1;
        tick();
        check("sess_active", 32'(dbg.state), 32'(ST_ACTIVE));
        check("sess_req_drop", 32'(ioctl_upload_req), 32'd0);
    endtask

    initial begin
        int cnt;
        int first_k;
        logic [24:0] a;

        for (int i = 0; i < IMG; i++) mem_model[i] = 8'($urandom);
        mem_model[5] = 8'hA5;
        rstn = 1'b0; save_trig = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd0;
        ioctl_rd = 1'b0; ioctl_addr = '0; mem_ack = 1'b0; mem_rdat = 8'h00; cmos_wr = 1'b0;
        last_din = FILL_BYTE;

        // Reset state
        tick(); tick();
        check("rst_din", 32'(ioctl_din), 32'hFF);
        check("rst_wait", 32'(ioctl_wait), 32'd0);
        check("rst_req", 32'(ioctl_upload_req), 32'd0);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dirty", 32'(dbg.dirty), 32'd0);
        rstn = 1'b1;
        tick();

        // Save trigger; host answers after 10 cycles of request
        save_trig = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            check("t1_req_high", 32'(ioctl_upload_req), 32'd1);
        end
        ioctl_upload = 1'b1;
        ioctl_index  = 8'd1;
        tick();
        check("t1_req_low", 32'(ioctl_upload_req), 32'd0);
        check("t1_state", 32'(dbg.state), 32'(ST_ACTIVE));
        check("t1_busy", 32'(busy), 32'd1);

        // Directed reads: addr 5 with 3-cycle RAM latency, then boundaries
        do_read(25'h0005, 3);
        do_read(25'h2000, 1);
        do_read(25'h1FFF, 1);
        do_read(25'h0000, 2);
        do_read(25'h1FFFFFF, 1);

        // Randomized reads
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) a = 25'($urandom);
            else a = 25'($urandom_range(0, IMG - 1));
            do_read(a, $urandom_range(1, 4));
        end

        // Host read during a pending fetch is ignored but flagged
        check("ovl_flag_clear", 32'(dbg.rd_overlap), 32'd0);
        ioctl_rd = 1'b1; ioctl_addr = 25'h0040;
        tick();
        ioctl_addr = 25'h0100;
        tick();
        ioctl_rd = 1'b0;
        check("ovl_mem_addr", 32'(mem_addr), 32'h40);
        check("ovl_flag", 32'(dbg.rd_overlap), 32'd1);
        mem_ack = 1'b1; mem_rdat = mem_model[13'h40];
        tick();
        mem_ack = 1'b0;
        check("ovl_din", 32'(ioctl_din), 32'(mem_model[13'h40]));
        last_din = mem_model[13'h40];

        // Upload drops while fetch is pending; dirty must survive
        cmos_wr = 1'b1;
        tick();
        cmos_wr = 1'b0;
        ioctl_rd = 1'b1; ioctl_addr = 25'h0010;
        tick();
        ioctl_rd = 1'b0;
        ioctl_upload = 1'b0;
        tick();
        check("abort_mem_rd", 32'(mem_rd), 32'd1);
        check("abort_wait", 32'(ioctl_wait), 32'd1);
        check("abort_state", 32'(dbg.state), 32'(ST_FETCH));
        tick();
        check("abort_mem_rd2", 32'(mem_rd), 32'd1);
        mem_ack = 1'b1; mem_rdat = ~mem_model[13'h10];
        tick();
        mem_ack = 1'b0;
        check("abort_mem_rd_done", 32'(mem_rd), 32'd0);
        check("abort_wait_done", 32'(ioctl_wait), 32'd0);
        check("abort_state_idle", 32'(dbg.state), 32'(ST_IDLE));
        check("abort_din_kept", 32'(ioctl_din), 32'(last_din));
        check("abort_dirty", 32'(dbg.dirty), 32'd1);

        // Upload end coinciding with a CMOS write keeps dirty
        start_session();
        ioctl_upload = 1'b0; cmos_wr = 1'b1;
        tick();
        cmos_wr = 1'b0;
        check("end_wr_state", 32'(dbg.state), 32'(ST_IDLE));
        check("end_wr_dirty", 32'(dbg.dirty), 32'd1);

        // Clean upload end clears dirty
        start_session();
        ioctl_upload = 1'b0;
        tick();
        check("end_state", 32'(dbg.state), 32'(ST_IDLE));
        check("end_dirty", 32'(dbg.dirty), 32'd0);

        // Host silent: request times out after exactly 100 cycles
        save_trig = 1'b0;
        tick();
        save_trig = 1'b1;
        tick();
        cnt = 0;
        while (ioctl_upload_req && cnt < 200) begin
            cnt++;
            if (cnt == 30) save_trig = 1'b0;
            if (cnt == 31) save_trig = 1'b1;
            tick();
        end
        check("tmo_req_cycles", 32'(cnt), 32'd100);
        check("tmo_state", 32'(dbg.state), 32'(ST_IDLE));
        check("tmo_busy", 32'(busy), 32'd0);
        repeat (5) tick();
        check("tmo_not_queued", 32'(ioctl_upload_req), 32'd0);

        // Autosave: writes at t0 and t0+20, request at t0+70 only with the feature
        cmos_wr = 1'b1;
        tick();
        cmos_wr = 1'b0;
        repeat (19) tick();
        cmos_wr = 1'b1;
        tick();
        cmos_wr = 1'b0;
        first_k = -1;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (ioctl_upload_req && first_k < 0) first_k = k;
        end
`ifdef SRAM_AUTOSAVE_EN
        check("autosave_rise", 32'(first_k), 32'd50);
`else
        check("autosave_none", 32'(first_k), 32'hFFFFFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
